multi_mode_ff_bank: RTL and testbench
=====================================

// Module: multi_mode_ff_bank
// PURPOSE
//  WIDTH-channel flip-flop bank; successor to the single-bit SR flip-flop.
//  Run-time mode selects SR, JK, D or T behaviour for all channels.
//  SR illegal input (S=R=1) resolves deterministically per parameter and is flagged.
//  Adds per-channel change strobes and sticky error flags for the counter/FSM blocks built on top.
// PARAMETERS
//  WIDTH       8      number of independent flip-flop channels (>=1)
//  RESET_VAL   0      WIDTH-bit value loaded into q on reset
//  SR_ILLEGAL  0      S=R=1 resolution: 0 hold, 1 set-dominant, 2 reset-dominant, 3 toggle
// PORTS
//  clk         in   1      rising-edge clock; all state changes on this edge only
//  reset       in   1      synchronous, active-low reset (0 = reset at next rising clk)
//  en          in   1      1 = update channels this edge; 0 = hold all state
//  mode        in   2      00 SR, 01 JK, 10 D, 11 T; sampled at the same edge as a/b
//  a           in   WIDTH  S / J / D / T input per channel
//  b           in   WIDTH  R / K input per channel; ignored in D and T modes
//  err_clr     in   1      1 = clear all sticky error bits this edge
//  q           out  WIDTH  flip-flop state
//  q_bar       out  WIDTH  always exactly ~q, never X
//  chg         out  WIDTH  1 for one cycle after an edge where q[i] changed
//  err         out  WIDTH  sticky: channel saw S=R=1 in SR mode while en=1
//  err_any     out  1      OR-reduction of err (registered, same timing as err)
// BEHAVIOUR
//  Reset (reset=0 at an edge), overriding en, err_clr and all other inputs:
//   - q=RESET_VAL, q_bar=~RESET_VAL, chg=0, err=0, err_any=0.
//  en=0: q, q_bar and err hold; chg=0 on the next edge; no error detection; err_clr still honoured.
//  en=1, next q per channel i (from a[i], b[i], q[i] before the edge):
//   - SR: 00 hold, 01 ->0, 10 ->1, 11 -> per SR_ILLEGAL.
//   - JK: 00 hold, 01 ->0, 10 ->1, 11 toggle.
//   - D: q=a[i].
//   - T: a[i]=1 toggles, a[i]=0 holds.
//  Latency:
//   - q reflects inputs sampled at edge N during cycle N+1; no combinational input-to-output path.
//   - chg[i] updates at the same edge as q; chg[i]=1 iff q[i] differs from its pre-edge value.
//  Error flag:
//   - err[i] sets when en=1, mode=SR and a[i]=b[i]=1.
//   - err_clr clears all bits unless a set condition occurs the same edge; set wins for that bit.
//   - err_any registered alongside err, from the next err value.
//  Mode switch is effective immediately (no pipeline); channel state is preserved across modes.
//  Reset asserted mid-sequence abandons the sequence; the first edge after release uses fresh inputs.
//  All outputs are registered; q_bar is a registered complement, not a separate state bit.
// TESTING
//  1 Reset: reset=0 one edge, RESET_VAL=8'hA5 -> q=A5, q_bar=5A, chg=00, err=00, err_any=0.
//  2 D mode, en=1, a=3C then en=0 with a=FF -> q=3C, chg=99 (A5^3C), then q holds 3C, chg=00.
//  3 JK mode, q=00, a=b=FF for 3 edges -> q FF,00,FF; chg=FF each cycle; err stays 00.
//  4 SR mode, q=0F, a=b=01, SR_ILLEGAL=0,1,2,3 -> q[0]=1,1,0,0; err=01 and err_any=1 in every case.
//  5 err_clr=1 with SR a=b=02 same edge, err=01 before -> err=02, err_any=1; next edge err_clr only -> 00.
//  6 T mode, a=81, en=1 for 2 edges then reset=0 mid-run -> q toggles bits 7,0 twice, then RESET_VAL.

Source files
------------

// File: rtl/multi_mode_ff_bank.sv
// WIDTH-channel flip-flop bank with run-time selectable SR/JK/D/T behaviour,
// per-channel change strobes and sticky SR-illegal error flags.
module multi_mode_ff_bank #(
  parameter int unsigned          WIDTH      = 8,
  parameter logic [WIDTH-1:0]     RESET_VAL  = '0,
  parameter int unsigned          SR_ILLEGAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic [WIDTH-1:0] chg,
  output logic [WIDTH-1:0] err,
  output logic             err_any
);

  typedef enum logic [1:0] {
    MODE_SR = 2'b00,
    MODE_JK = 2'b01,
    MODE_D  = 2'b10,
    MODE_T  = 2'b11
  } mode_e;

  localparam int unsigned SR_HOLD   = 0;
  localparam int unsigned SR_SET    = 1;
  localparam int unsigned SR_RESET  = 2;

  mode_e            mode_s;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] err_set;
  logic [WIDTH-1:0] err_nxt;
  logic [WIDTH-1:0] chg_nxt;

  assign mode_s = mode_e'(mode);

  // Resolve S=R=1 according to the build-time policy.
  function automatic logic sr_illegal_q(input logic cur);
    if (SR_ILLEGAL == SR_HOLD)       return cur;
    else if (SR_ILLEGAL == SR_SET)   return 1'b1;
    else if (SR_ILLEGAL == SR_RESET) return 1'b0;
    else                             return ~cur;
  endfunction

  // Per-channel next state and SR-illegal detection.
  always_comb begin
    q_nxt   = q;
    err_set = '0;
    if (en) begin
      for (int i = 0; i < WIDTH; i++) begin
        unique case (mode_s)
          MODE_SR: begin
            unique case ({a[i], b[i]})
              2'b00:   q_nxt[i] = q[i];
              2'b01:   q_nxt[i] = 1'b0;
              2'b10:   q_nxt[i] = 1'b1;
              default: begin
                q_nxt[i]   = sr_illegal_q(q[i]);
                err_set[i] = 1'b1;
              end
            endcase
          end
          MODE_JK: begin
            unique case ({a[i], b[i]})
              2'b00:   q_nxt[i] = q[i];
              2'b01:   q_nxt[i] = 1'b0;
              2'b10:   q_nxt[i] = 1'b1;
              default: q_nxt[i] = ~q[i];
            endcase
          end
          MODE_D:  q_nxt[i] = a[i];
          default: q_nxt[i] = q[i] ^ a[i];
        endcase
      end
    end
  end

  // A set condition on the same edge as a clear keeps that bit set.
  always_comb begin
    err_nxt = err_clr ? err_set : (err | err_set);
    chg_nxt = q_nxt ^ q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      q       <= RESET_VAL;
      q_bar   <= ~RESET_VAL;
      chg     <= '0;
      err     <= '0;
      err_any <= 1'b0;
    end else begin
      q       <= q_nxt;
      q_bar   <= ~q_nxt;
      chg     <= chg_nxt;
      err     <= err_nxt;
      err_any <= |err_nxt;
    end
  end

endmodule

// File: tb/tb_multi_mode_ff_bank.sv
// Directed bench for multi_mode_ff_bank: one instance per SR_ILLEGAL policy, shared stimulus.
module tb_multi_mode_ff_bank;

  localparam int unsigned W  = 8;
  localparam int unsigned NI = 4;
  localparam logic [W-1:0] RV = 8'hA5;

  logic         clk;
  logic         reset;
  logic         en;
  logic [1:0]   mode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         err_clr;

  logic [W-1:0] q_w     [NI];
  logic [W-1:0] q_bar_w [NI];
  logic [W-1:0] chg_w   [NI];
  logic [W-1:0] err_w   [NI];
  logic         any_w   [NI];

  int checks = 0;
  int errors = 0;

  for (genvar k = 0; k < NI; k++) begin : g_dut
    multi_mode_ff_bank #(
      .WIDTH(W), .RESET_VAL(RV), .SR_ILLEGAL(k)
    ) dut (
      .clk(clk), .reset(reset), .en(en), .mode(mode), .a(a), .b(b),
      .err_clr(err_clr),
      .q(q_w[k]), .q_bar(q_bar_w[k]), .chg(chg_w[k]),
      .err(err_w[k]), .err_any(any_w[k])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-instance expected q/chg packed as {inst3, inst2, inst1, inst0}.
  typedef struct {
    string             name;
    logic              rst;
    logic              en;
    logic [1:0]        mode;
    logic [W-1:0]      a;
    logic [W-1:0]      b;
    logic              clr;
    logic [NI-1:0][W-1:0] eq;
    logic [NI-1:0][W-1:0] echg;
    logic [W-1:0]      eerr;
    logic              eany;
  } vec_t;

  vec_t vecs[14];

  task automatic cmp(input string nm, input int k, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d: got %h expected %h", nm, k, act, exp);
    end
  endtask

  task automatic step(input string nm, input logic rst, input logic e, input logic [1:0] m,
                      input logic [W-1:0] av, input logic [W-1:0] bv, input logic clr,
                      input logic [NI-1:0][W-1:0] eq, input logic [NI-1:0][W-1:0] echg,
                      input logic [W-1:0] eerr, input logic eany);
    @(negedge clk);
    reset = rst; en = e; mode = m; a = av; b = bv; err_clr = clr;
    @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      cmp({nm, ".q"},     k, q_w[k],     eq[k]);
      cmp({nm, ".q_bar"}, k, q_bar_w[k], ~eq[k]);
      cmp({nm, ".chg"},   k, chg_w[k],   echg[k]);
      cmp({nm, ".err"},   k, err_w[k],   eerr);
      cmp({nm, ".err_any"}, k, W'(any_w[k]), W'(eany));
    end
  endtask

  function automatic vec_t mk(input string nm, input logic rst, input logic e,
                              input logic [1:0] m, input logic [W-1:0] av,
                              input logic [W-1:0] bv, input logic clr,
                              input logic [W-1:0] eq, input logic [W-1:0] echg,
                              input logic [W-1:0] eerr, input logic eany);
    vec_t v;
    v.name = nm; v.rst = rst; v.en = e; v.mode = m; v.a = av; v.b = bv; v.clr = clr;
    v.eq = {NI{eq}}; v.echg = {NI{echg}}; v.eerr = eerr; v.eany = eany;
    return v;
  endfunction

  initial begin
    reset = 1'b1; en = 1'b0; mode = 2'b00; a = '0; b = '0; err_clr = 1'b0;

    //             name        rst  en  mode   a      b      clr  q      chg    err    any
    vecs[0]  = mk("reset",     0,   1, 2'b10, 8'hFF, 8'hFF, 1,  8'hA5, 8'h00, 8'h00, 0);
    vecs[1]  = mk("d_3c",      1,   1, 2'b10, 8'h3C, 8'h00, 0,  8'h3C, 8'h99, 8'h00, 0);
    vecs[2]  = mk("d_hold",    1,   0, 2'b10, 8'hFF, 8'h00, 0,  8'h3C, 8'h00, 8'h00, 0);
    vecs[3]  = mk("d_00",      1,   1, 2'b10, 8'h00, 8'hFF, 0,  8'h00, 8'h3C, 8'h00, 0);
    vecs[4]  = mk("jk_tog1",   1,   1, 2'b01, 8'hFF, 8'hFF, 0,  8'hFF, 8'hFF, 8'h00, 0);
    vecs[5]  = mk("jk_tog2",   1,   1, 2'b01, 8'hFF, 8'hFF, 0,  8'h00, 8'hFF, 8'h00, 0);
    vecs[6]  = mk("jk_tog3",   1,   1, 2'b01, 8'hFF, 8'hFF, 0,  8'hFF, 8'hFF, 8'h00, 0);
    vecs[7]  = mk("jk_setrst", 1,   1, 2'b01, 8'h0F, 8'hF0, 0,  8'h0F, 8'hF0, 8'h00, 0);
    vecs[8]  = mk("jk_hold",   1,   1, 2'b01, 8'h00, 8'h00, 0,  8'h0F, 8'h00, 8'h00, 0);
    vecs[9]  = mk("sr_legal",  1,   1, 2'b00, 8'h30, 8'h01, 0,  8'h3E, 8'h31, 8'h00, 0);
    vecs[10] = mk("t_81a",     1,   1, 2'b11, 8'h81, 8'hFF, 0,  8'hBF, 8'h81, 8'h00, 0);
    vecs[11] = mk("t_81b",     1,   1, 2'b11, 8'h81, 8'hFF, 0,  8'h3E, 8'h81, 8'h00, 0);
    vecs[12] = mk("t_midrst",  0,   1, 2'b11, 8'hFF, 8'h00, 0,  8'hA5, 8'h00, 8'h00, 0);
    vecs[13] = mk("d_0f",      1,   1, 2'b10, 8'h0F, 8'h00, 0,  8'h0F, 8'hAA, 8'h00, 0);

    for (int i = 0; i < 14; i++)
      step(vecs[i].name, vecs[i].rst, vecs[i].en, vecs[i].mode, vecs[i].a, vecs[i].b,
           vecs[i].clr, vecs[i].eq, vecs[i].echg, vecs[i].eerr, vecs[i].eany);

    // SR illegal input from q=0F under each resolution policy (instances 0..3).
    step("sr_ill_b0", 1, 1, 2'b00, 8'h01, 8'h01, 0,
         {8'h0E, 8'h0E, 8'h0F, 8'h0F}, {8'h01, 8'h01, 8'h00, 8'h00}, 8'h01, 1);
    // Clear and set on the same edge: new set bit survives, old bit cleared.
    step("sr_clr_set", 1, 1, 2'b00, 8'h02, 8'h02, 1,
         {8'h0C, 8'h0C, 8'h0F, 8'h0F}, {8'h02, 8'h02, 8'h00, 8'h00}, 8'h02, 1);
    // en=0: illegal SR ignored, clear still honoured.
    step("clr_only", 1, 0, 2'b00, 8'hFF, 8'hFF, 1,
         {8'h0C, 8'h0C, 8'h0F, 8'h0F}, {NI{8'h00}}, 8'h00, 0);
    step("sr_ill_b2", 1, 1, 2'b00, 8'h04, 8'h04, 0,
         {8'h08, 8'h08, 8'h0F, 8'h0F}, {8'h04, 8'h04, 8'h00, 8'h00}, 8'h04, 1);
    step("err_sticky", 1, 1, 2'b01, 8'h00, 8'h00, 0,
         {8'h08, 8'h08, 8'h0F, 8'h0F}, {NI{8'h00}}, 8'h04, 1);
    // Reset overrides an illegal SR input presented on the same edge.
    step("rst_over", 0, 1, 2'b00, 8'hFF, 8'hFF, 0,
         {NI{8'hA5}}, {NI{8'h00}}, 8'h00, 0);
    step("post_rst", 1, 1, 2'b10, 8'h5A, 8'h00, 0,
         {NI{8'h5A}}, {NI{8'hFF}}, 8'h00, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
